// File: rtl/agc_tp_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | agc_tp_sequencer : phase / time-pulse / MCT sequencer with binary scaler   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module agc_tp_sequencer #(
    parameter int DIV        = 2,
    parameter int NPHASE     = 4,
    parameter int NTP        = 12,
    parameter int SCALER_PRE = 1,
    parameter int SCALER_W   = 17
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    STOP,
    input  logic                    STEP,
    output logic [NPHASE-1:0]       PHS,
    output logic [NTP-1:0]          TP,
    output logic [$clog2(NTP)-1:0]  TP_IDX,
    output logic                    MCT_END,
    output logic                    RUNNING,
    output logic [SCALER_W-1:0]     FS,
    output logic [SCALER_W-1:0]     F_STB
);

    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(NPHASE);
    localparam int TW  = $clog2(NTP);
    localparam int PRW = (SCALER_PRE > 1) ? $clog2(SCALER_PRE) : 1;

    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
    localparam logic [PW-1:0]  PH_LAST  = PW'(NPHASE - 1);
    localparam logic [TW-1:0]  TP_LAST  = TW'(NTP - 1);
    localparam logic [PRW-1:0] PRE_LAST = PRW'(SCALER_PRE - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_STEPM = 2'd2
    } state_t;

    state_t                state_q;
    logic [DW-1:0]         div_q;
    logic [PW-1:0]         ph_q;
    logic [TW-1:0]         tp_q;
    logic [PRW-1:0]        pre_q;
    logic [SCALER_W-1:0]   fs_q;
    logic [SCALER_W-1:0]   fstb_q;
    logic                  step_prev_q;

    logic                  run_w;
    logic                  mct_end_w;

    assign run_w     = (state_q != S_HALT);
    assign mct_end_w = run_w && (div_q == DIV_LAST) && (ph_q == PH_LAST) && (tp_q == TP_LAST);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= S_RUN;
            div_q       <= '0;
            ph_q        <= '0;
            tp_q        <= '0;
            pre_q       <= '0;
            fs_q        <= '0;
            fstb_q      <= '0;
            step_prev_q <= 1'b0;
        end else begin
            step_prev_q <= STEP;
            fstb_q      <= '0;
            case (state_q)
                S_HALT: begin
                    // Counters already sit at zero, so the next active cycle starts a fresh MCT.
                    if (!STOP) begin
                        state_q <= S_RUN;
                    end else if (STEP && !step_prev_q) begin
                        state_q <= S_STEPM;
                    end
                end
                default: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (ph_q == PH_LAST) begin
                            ph_q <= '0;
                            tp_q <= (tp_q == TP_LAST) ? '0 : tp_q + 1'b1;
                        end else begin
                            ph_q <= ph_q + 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                    if (mct_end_w) begin
                        if (pre_q == PRE_LAST) begin
                            pre_q  <= '0;
                            fs_q   <= fs_q + 1'b1;
                            fstb_q <= ~fs_q & (fs_q + 1'b1);
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                        if (state_q == S_STEPM || STOP) begin
                            state_q <= S_HALT;
                        end
                    end
                end
            endcase
        end
    end

    assign PHS     = run_w ? (NPHASE'(1) << ph_q) : '0;
    assign TP      = run_w ? (NTP'(1) << tp_q) : '0;
    assign TP_IDX  = tp_q;
    assign MCT_END = mct_end_w;
    assign RUNNING = run_w;
    assign FS      = fs_q;
    assign F_STB   = fstb_q;

endmodule
`default_nettype wire

// File: tb/tb_agc_tp_sequencer.sv
`default_nettype none
// Bench for agc_tp_sequencer: cycle model feeding a scoreboard plus directed checks.
module tb_agc_tp_sequencer;

    logic        CLOCK, RESET, STOP, STEP;
    logic [3:0]  PHS;
    logic [11:0] TP;
    logic [3:0]  TP_IDX;
    logic        MCT_END, RUNNING;
    logic [3:0]  FS, F_STB;

    agc_tp_sequencer #(.DIV(2), .NPHASE(4), .NTP(12), .SCALER_PRE(2), .SCALER_W(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .STOP(STOP), .STEP(STEP),
        .PHS(PHS), .TP(TP), .TP_IDX(TP_IDX), .MCT_END(MCT_END),
        .RUNNING(RUNNING), .FS(FS), .F_STB(F_STB)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    typedef struct {
        logic [3:0]  phs;
        logic [11:0] tp;
        logic [3:0]  tpidx;
        logic        me;
        logic        run;
        logic [3:0]  fs;
        logic [3:0]  fstb;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   me_cnt, run_cnt;

    // Reference model: position inside the MCT is a single 0..95 cycle index.
    int         m_st;     // 0 run, 1 halt, 2 single step
    int         m_cyc;
    int         m_pre;
    logic [3:0] m_fs, m_fstb;
    logic       m_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic st);
        logic edge_st;
        if (r) begin
            m_st = 0; m_cyc = 0; m_pre = 0; m_fs = '0; m_fstb = '0; m_prev = 1'b0;
        end else begin
            edge_st = st && !m_prev;
            m_prev  = st;
            m_fstb  = '0;
            if (m_st == 1) begin
                if (!s) m_st = 0;
                else if (edge_st) m_st = 2;
            end else begin
                if (m_cyc == 95) begin
                    m_cyc = 0;
                    if (m_pre == 1) begin
                        m_pre  = 0;
                        m_fstb = ~m_fs & (m_fs + 4'd1);
                        m_fs   = m_fs + 4'd1;
                    end else begin
                        m_pre = m_pre + 1;
                    end
                    if (m_st == 2 || s) m_st = 1;
                end else begin
                    m_cyc = m_cyc + 1;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.run   = (m_st != 1);
        e.phs   = e.run ? 4'(1 << ((m_cyc / 2) % 4)) : 4'd0;
        e.tp    = e.run ? 12'(1 << (m_cyc / 8)) : 12'd0;
        e.tpidx = e.run ? 4'(m_cyc / 8) : 4'd0;
        e.me    = e.run && (m_cyc == 95);
        e.fs    = m_fs;
        e.fstb  = m_fstb;
        return e;
    endfunction

    task automatic cyc(input logic r, input logic s, input logic st);
        exp_t e;
        RESET = r; STOP = s; STEP = st;
        model_step(r, s, st);
        sb_q.push_back(model_out());
        @(posedge CLOCK);
        #1;
        e = sb_q.pop_front();
        chk("phs",    32'(PHS),     32'(e.phs));
        chk("tp",     32'(TP),      32'(e.tp));
        chk("tp_idx", 32'(TP_IDX),  32'(e.tpidx));
        chk("mct_end",32'(MCT_END), 32'(e.me));
        chk("running",32'(RUNNING), 32'(e.run));
        chk("fs",     32'(FS),      32'(e.fs));
        chk("f_stb",  32'(F_STB),   32'(e.fstb));
        me_cnt  += int'(MCT_END);
        run_cnt += int'(RUNNING);
    endtask

    initial begin
        logic [3:0] last_fs;
        logic [2:0] seen;
        logic       found;
        RESET = 1'b1; STOP = 1'b0; STEP = 1'b0;
        m_st = 0; m_cyc = 0; m_pre = 0; m_fs = '0; m_fstb = '0; m_prev = 1'b0;
        @(posedge CLOCK); #1;

        // Reset state, then free run for three MCTs.
        cyc(1, 0, 0);
        chk("rst_phs", 32'(PHS), 32'h1);
        chk("rst_tp",  32'(TP),  32'h1);
        chk("rst_run", 32'(RUNNING), 32'h1);
        me_cnt = 0;
        for (int i = 0; i < 288; i++) cyc(0, 0, 0);
        chk("t1_mct_cnt", 32'(me_cnt), 32'd3);

        // STOP raised mid-MCT halts only at the boundary, and is held.
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);
        run_cnt = 0;
        for (int i = 0; i < 120; i++) cyc(0, 1, 0);
        chk("t2_run_cycles", 32'(run_cnt), 32'd85);
        chk("t2_halt_phs", 32'(PHS), 32'h0);
        chk("t2_halt_run", 32'(RUNNING), 32'h0);
        cyc(0, 0, 0);
        chk("t2_resume_phs", 32'(PHS), 32'h1);
        chk("t2_resume_tp0", 32'(TP[0]), 32'h1);

        // Single step: exactly one MCT, second STEP pulse ignored.
        for (int i = 0; i < 100; i++) cyc(0, 1, 0);
        me_cnt = 0; run_cnt = 0;
        cyc(0, 1, 1);
        for (int i = 0; i < 200; i++) cyc(0, 1, (i == 39));
        chk("t3_step_run", 32'(run_cnt), 32'd96);
        chk("t3_step_mct", 32'(me_cnt), 32'd1);
        chk("t3_halted", 32'(RUNNING), 32'h0);

        // Scaler strobes across 3->4, 4->5 and the 15->0 wrap.
        seen = '0;
        last_fs = FS;
        for (int i = 0; i < 17 * 192; i++) begin
            cyc(0, 0, 0);
            if (last_fs == 4'd3 && FS == 4'd4) begin chk("t4_stb_3to4", 32'(F_STB), 32'h4); seen[0] = 1'b1; end
            if (last_fs == 4'd4 && FS == 4'd5) begin chk("t4_stb_4to5", 32'(F_STB), 32'h1); seen[1] = 1'b1; end
            if (last_fs == 4'd15 && FS == 4'd0) begin chk("t4_stb_wrap", 32'(F_STB), 32'h0); seen[2] = 1'b1; end
            last_fs = FS;
        end
        chk("t4_events_seen", 32'(seen), 32'h7);

        // Reset at cycle 50 of an MCT with FS=5.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (m_fs == 4'd5 && m_cyc == 50 && m_st == 0) found = 1'b1;
            else cyc(0, 0, 0);
        end
        chk("t5_reached", 32'(found), 32'h1);
        chk("t5_pre_fs", 32'(FS), 32'h5);
        cyc(1, 0, 0);
        chk("t5_phs", 32'(PHS), 32'h1);
        chk("t5_tp",  32'(TP), 32'h1);
        chk("t5_fs",  32'(FS), 32'h0);
        chk("t5_run", 32'(RUNNING), 32'h1);
        chk("t5_me",  32'(MCT_END), 32'h0);

        // STOP falls in the same cycle STEP rises: continuous running.
        for (int i = 0; i < 100; i++) cyc(0, 1, 0);
        me_cnt = 0;
        cyc(0, 0, 1);
        for (int i = 0; i < 199; i++) cyc(0, 0, 0);
        chk("t6_mct_cnt", 32'(me_cnt), 32'd2);
        chk("t6_running", 32'(RUNNING), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
